// File: rtl/ama_riscv_csr.sv
// rtl/ama_riscv_csr.sv - EX-stage CSR responder: mscratch, tohost, cycle/time/instret counters
// Counters are built only with `define CSR_COUNTERS_EN; otherwise counter CSRs read 0.
module ama_riscv_csr #(
  parameter logic [11:0] TOHOST_ADDR   = 12'h51E,
  parameter logic [11:0] MSCRATCH_ADDR = 12'h340
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        csr_en,
  input  logic        csr_we,
  input  logic        csr_ui,
  input  logic [1:0]  csr_op_sel,
  input  logic [11:0] csr_addr,
  input  logic [31:0] rs1_data,
  input  logic [4:0]  uimm,
  input  logic        inst_retired,
  output logic [31:0] csr_rdata,
  output logic [31:0] tohost,
  output logic        illegal_csr
);

  localparam logic [11:0] CYCLE_ADDR    = 12'hC00;
  localparam logic [11:0] TIME_ADDR     = 12'hC01;
  localparam logic [11:0] INSTRET_ADDR  = 12'hC02;
  localparam logic [11:0] CYCLEH_ADDR   = 12'hC80;
  localparam logic [11:0] TIMEH_ADDR    = 12'hC81;
  localparam logic [11:0] INSTRETH_ADDR = 12'hC82;

  localparam logic [1:0] OP_ASSIGN = 2'b01;
  localparam logic [1:0] OP_SET    = 2'b10;
  localparam logic [1:0] OP_CLEAR  = 2'b11;

  logic [31:0] mscratch;
  logic [31:0] cycle_lo, cycle_hi, instret_lo, instret_hi;

  logic        accept;
  logic [31:0] operand;
  logic [31:0] old_val;
  logic [31:0] new_val;
  logic        addr_hit;
  logic        addr_ro;
  logic        wr_en;
  logic        illegal_next;

`ifdef CSR_COUNTERS_EN
  logic [63:0] cycle_cnt;
  logic [63:0] instret_cnt;

  // Full 64-bit adders: the low-to-high carry lands in the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 64'd1;
      if (inst_retired) instret_cnt <= instret_cnt + 64'd1;
    end
  end

  assign cycle_lo   = cycle_cnt[31:0];
  assign cycle_hi   = cycle_cnt[63:32];
  assign instret_lo = instret_cnt[31:0];
  assign instret_hi = instret_cnt[63:32];
`else
  logic unused_inst_retired;
  assign unused_inst_retired = inst_retired;

  assign cycle_lo   = '0;
  assign cycle_hi   = '0;
  assign instret_lo = '0;
  assign instret_hi = '0;
`endif

  assign accept  = csr_en && !clear && !rst;
  assign operand = csr_ui ? {27'b0, uimm} : rs1_data;

  // Address decode; counter addresses stay mapped (read-only) even when counters are absent.
  always_comb begin
    old_val  = '0;
    addr_hit = 1'b1;
    addr_ro  = 1'b0;
    case (csr_addr)
      MSCRATCH_ADDR: old_val = mscratch;
      TOHOST_ADDR:   old_val = tohost;
      CYCLE_ADDR, TIME_ADDR: begin
        old_val = cycle_lo;
        addr_ro = 1'b1;
      end
      CYCLEH_ADDR, TIMEH_ADDR: begin
        old_val = cycle_hi;
        addr_ro = 1'b1;
      end
      INSTRET_ADDR: begin
        old_val = instret_lo;
        addr_ro = 1'b1;
      end
      INSTRETH_ADDR: begin
        old_val = instret_hi;
        addr_ro = 1'b1;
      end
      default: addr_hit = 1'b0;
    endcase
  end

  always_comb begin
    new_val = old_val;
    case (csr_op_sel)
      OP_ASSIGN: new_val = operand;
      OP_SET:    new_val = old_val | operand;
      OP_CLEAR:  new_val = old_val & ~operand;
      default:   new_val = old_val;
    endcase
  end

  assign wr_en        = accept && csr_we && addr_hit && !addr_ro && (csr_op_sel != 2'b00);
  assign illegal_next = accept && (!addr_hit || (addr_ro && csr_we));

  always_ff @(posedge clk) begin
    if (rst) begin
      mscratch <= '0;
      tohost   <= '0;
    end else if (wr_en) begin
      if (csr_addr == MSCRATCH_ADDR) mscratch <= new_val;
      else if (csr_addr == TOHOST_ADDR) tohost <= new_val;
    end
  end

  // Read data is the pre-edge value; unmapped or suppressed requests return 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      csr_rdata   <= '0;
      illegal_csr <= 1'b0;
    end else begin
      csr_rdata   <= (accept && addr_hit) ? old_val : 32'h0;
      illegal_csr <= illegal_next;
    end
  end

endmodule

// File: tb/tb_ama_riscv_csr.sv
// tb/tb_ama_riscv_csr.sv - directed and randomized bench for ama_riscv_csr
// Honours CSR_COUNTERS_EN to decide whether counter CSRs carry live values.
module tb_ama_riscv_csr;

`ifdef CSR_COUNTERS_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        csr_en = 1'b0;
  logic        csr_we = 1'b0;
  logic        csr_ui = 1'b0;
  logic [1:0]  csr_op_sel = 2'b00;
  logic [11:0] csr_addr = 12'h0;
  logic [31:0] rs1_data = 32'h0;
  logic [4:0]  uimm = 5'h0;
  logic        inst_retired = 1'b0;
  logic [31:0] csr_rdata;
  logic [31:0] tohost;
  logic        illegal_csr;

  ama_riscv_csr dut (
    .clk(clk), .rst(rst), .clear(clear), .csr_en(csr_en), .csr_we(csr_we),
    .csr_ui(csr_ui), .csr_op_sel(csr_op_sel), .csr_addr(csr_addr),
    .rs1_data(rs1_data), .uimm(uimm), .inst_retired(inst_retired),
    .csr_rdata(csr_rdata), .tohost(tohost), .illegal_csr(illegal_csr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Architectural model state
  logic [31:0] m_ms = 0, m_th = 0;
  logic [63:0] m_cyc = 0, m_ins = 0;
  logic [31:0] exp_rdata = 0;
  logic        exp_ill = 0;
  bit          model_live = 0;

  bit          l_hit, l_ro;
  logic [31:0] l_old, l_op, l_new;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void lookup(input logic [11:0] a, output bit hit, output bit ro,
                                 output logic [31:0] v);
    hit = 1; ro = 1; v = 0;
    case (a)
      12'h340: begin ro = 0; v = m_ms; end
      12'h51E: begin ro = 0; v = m_th; end
      12'hC00, 12'hC01: v = CNT_EN ? m_cyc[31:0] : 32'h0;
      12'hC80, 12'hC81: v = CNT_EN ? m_cyc[63:32] : 32'h0;
      12'hC02: v = CNT_EN ? m_ins[31:0] : 32'h0;
      12'hC82: v = CNT_EN ? m_ins[63:32] : 32'h0;
      default: begin hit = 0; ro = 0; end
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_ms = 0; m_th = 0; m_cyc = 0; m_ins = 0;
      exp_rdata = 0; exp_ill = 0;
      model_live = 1;
    end else begin
      exp_rdata = 0;
      exp_ill = 0;
      if (csr_en && !clear) begin
        lookup(csr_addr, l_hit, l_ro, l_old);
        if (!l_hit) exp_ill = 1;
        else begin
          exp_rdata = l_old;
          if (csr_we && l_ro) exp_ill = 1;
          else if (csr_we && csr_op_sel != 2'b00) begin
            l_op = csr_ui ? {27'b0, uimm} : rs1_data;
            case (csr_op_sel)
              2'b01:   l_new = l_op;
              2'b10:   l_new = l_old | l_op;
              default: l_new = l_old & ~l_op;
            endcase
            if (csr_addr == 12'h340) m_ms = l_new;
            else m_th = l_new;
          end
        end
      end
      m_cyc = m_cyc + 1;
      if (inst_retired) m_ins = m_ins + 1;
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      check("cmp_rdata", csr_rdata, exp_rdata);
      check("cmp_illegal", {31'b0, illegal_csr}, {31'b0, exp_ill});
      check("cmp_tohost", tohost, m_th);
    end
  end

  task automatic drive(input bit en, input bit we, input bit ui, input logic [1:0] op,
                       input logic [11:0] a, input logic [31:0] r1, input logic [4:0] u,
                       input bit clr);
    csr_en = en; csr_we = we; csr_ui = ui; csr_op_sel = op;
    csr_addr = a; rs1_data = r1; uimm = u; clear = clr;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(0, 0, 0, 2'b00, 12'h0, 32'h0, 5'h0, 0);
  endtask

  logic [11:0] addr_pool [10];

  initial begin
    addr_pool = '{12'h340, 12'h51E, 12'hC00, 12'hC80, 12'hC01,
                  12'hC81, 12'hC02, 12'hC82, 12'h7C0, 12'h000};
    rst = 1;
    repeat (2) @(negedge clk);
    check("reset_rdata", csr_rdata, 32'h0);
    check("reset_illegal", {31'b0, illegal_csr}, 32'h0);
    check("reset_tohost", tohost, 32'h0);
    rst = 0;

    repeat (10) idle();
    drive(1, 0, 0, 2'b00, 12'hC00, 32'h0, 5'h0, 0);
    check("cycle_after_10", csr_rdata, CNT_EN ? 32'd10 : 32'd0);
    check("cycle_read_legal", {31'b0, illegal_csr}, 32'h0);

    drive(1, 1, 0, 2'b01, 12'h340, 32'hA5A5_0000, 5'h0, 0);
    check("ms_assign_old", csr_rdata, 32'h0);
    drive(1, 1, 1, 2'b10, 12'h340, 32'hFFFF_FFFF, 5'd5, 0);
    check("ms_set_old", csr_rdata, 32'hA5A5_0000);
    drive(1, 1, 0, 2'b11, 12'h340, 32'hA500_0000, 5'h0, 0);
    check("ms_clear_old", csr_rdata, 32'hA5A5_0005);
    drive(1, 0, 0, 2'b00, 12'h340, 32'h0, 5'h0, 0);
    check("ms_final", csr_rdata, 32'h00A5_0005);

    drive(1, 1, 0, 2'b01, 12'h51E, 32'h1, 5'h0, 0);
    check("tohost_write", tohost, 32'h1);

    inst_retired = 1;
    repeat (3) idle();
    inst_retired = 0;
    drive(1, 1, 0, 2'b01, 12'hC02, 32'hFFFF_FFFF, 5'h0, 0);
    check("instret_ro_rdata", csr_rdata, CNT_EN ? 32'd3 : 32'd0);
    check("instret_ro_illegal", {31'b0, illegal_csr}, 32'h1);
    idle();
    check("illegal_one_cycle", {31'b0, illegal_csr}, 32'h0);
    drive(1, 0, 0, 2'b00, 12'hC02, 32'h0, 5'h0, 0);
    check("instret_unchanged", csr_rdata, CNT_EN ? 32'd3 : 32'd0);

    drive(1, 0, 0, 2'b00, 12'h7C0, 32'h0, 5'h0, 0);
    check("unmapped_rdata", csr_rdata, 32'h0);
    check("unmapped_illegal", {31'b0, illegal_csr}, 32'h1);
    drive(1, 0, 0, 2'b00, 12'h7C0, 32'h0, 5'h0, 1);
    check("unmapped_clear_illegal", {31'b0, illegal_csr}, 32'h0);
    drive(1, 1, 0, 2'b01, 12'h340, 32'h1234_5678, 5'h0, 1);
    check("clear_ms_rdata", csr_rdata, 32'h0);
    drive(1, 0, 0, 2'b00, 12'h340, 32'h0, 5'h0, 0);
    check("clear_no_write", csr_rdata, 32'h00A5_0005);

`ifdef CSR_COUNTERS_EN
    dut.cycle_cnt = 64'h0000_0000_FFFF_FFFF;
    m_cyc = 64'h0000_0000_FFFF_FFFF;
    idle();
    drive(1, 0, 0, 2'b00, 12'hC00, 32'h0, 5'h0, 0);
    check("carry_cycle_lo", csr_rdata, 32'h0);
    drive(1, 0, 0, 2'b00, 12'hC80, 32'h0, 5'h0, 0);
    check("carry_cycle_hi", csr_rdata, 32'h1);
`endif

    rst = 1;
    drive(1, 1, 0, 2'b01, 12'h340, 32'hDEAD_BEEF, 5'h0, 0);
    rst = 0;
    drive(1, 0, 0, 2'b00, 12'h340, 32'h0, 5'h0, 0);
    check("rst_mid_write", csr_rdata, 32'h0);

    for (int i = 0; i < 3000; i++) begin
      logic [11:0] a;
      a = addr_pool[$urandom_range(0, 9)];
      if (a == 12'h000) a = 12'($urandom);
      rst = ($urandom_range(0, 199) == 0);
      inst_retired = $urandom_range(0, 1);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 1),
            2'($urandom), a, $urandom, 5'($urandom), $urandom_range(0, 7) == 0);
    end
    rst = 0;
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
